// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] OP_SHL  = 4'b0000;
  localparam logic [3:0] OP_SHR  = 4'b0001;
  localparam logic [3:0] OP_ROL  = 4'b0010;
  localparam logic [3:0] OP_ROR  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_ADC  = 4'b1001;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_SBC  = 4'b1011;
  localparam logic [3:0] OP_AND  = 4'b1100;
  localparam logic [3:0] OP_OR   = 4'b1101;
  localparam logic [3:0] OP_XOR  = 4'b1110;
  localparam logic [3:0] OP_ANDN = 4'b1111;

  // Arithmetic ops (ADD/ADC/SUB/SBC) are the only ones that own the carry flag.
  function automatic logic is_carry_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_arbiter_picker.sv
// Two-way round-robin picker: one-hot grant, ties go to the side not granted last.
module alu_rr_picker (
  input  logic [1:0] i_valid,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  assign o_grant[0] = i_valid[0] & (~i_valid[1] | i_last);
  assign o_grant[1] = i_valid[1] & (~i_valid[0] | ~i_last);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters (IDLE/EXEC/RESP).
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      reqValid,
  output logic [1:0]      reqReady,
  input  logic [1:0][3:0] reqOp,
  input  logic [1:0][7:0] reqA,
  input  logic [1:0][7:0] reqB,
  input  logic [1:0][2:0] reqShift,
  output logic [1:0]      respValid,
  input  logic [1:0]      respReady,
  output logic [7:0]      respResult,
  output logic            respCarry,
  output logic            respZero,
  output logic [7:0]      aluA,
  output logic [7:0]      aluB,
  output logic [3:0]      aluOp,
  output logic            aluCarryIn,
  output logic [2:0]      aluShift,
  input  logic [7:0]      aluResult,
  input  logic            aluCarryOut,
  input  logic            aluZero
);

  state_e     r_state;
  logic [3:0] r_op;
  logic [7:0] r_a, r_b;
  logic [2:0] r_shift;
  logic       r_owner;
  logic       r_last;
  logic [1:0] r_carry;
  logic [7:0] r_result;
  logic       r_co, r_zero;

  logic [1:0] w_grant;
  logic       w_sel, w_idle, w_exec, w_resp;

  alu_rr_picker u_picker (
    .i_valid (reqValid),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  assign w_sel  = w_grant[1];
  assign w_idle = (r_state == ST_IDLE) & ~rst;
  assign w_exec = (r_state == ST_EXEC) & ~rst;
  assign w_resp = (r_state == ST_RESP) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_shift  <= '0;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_carry  <= '0;
      r_result <= '0;
      r_co     <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (|w_grant) begin
          r_op    <= reqOp[w_sel];
          r_a     <= reqA[w_sel];
          r_b     <= reqB[w_sel];
          r_shift <= reqShift[w_sel];
          r_owner <= w_sel;
          r_last  <= w_sel;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_result <= aluResult;
          r_co     <= aluCarryOut;
          r_zero   <= aluZero;
          if (is_carry_op(r_op)) r_carry[r_owner] <= aluCarryOut;
          r_state  <= ST_RESP;
        end
        ST_RESP: if (respReady[r_owner]) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Picker grant is already qualified by valid, so it doubles as ready.
  assign reqReady   = w_idle ? w_grant : 2'b00;
  assign respValid  = w_resp ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign respResult = rst ? 8'h00 : r_result;
  assign respCarry  = ~rst & r_co;
  assign respZero   = ~rst & r_zero;

  assign aluA       = w_exec ? r_a     : 8'h00;
  assign aluB       = w_exec ? r_b     : 8'h00;
  assign aluOp      = w_exec ? r_op    : 4'h0;
  assign aluShift   = w_exec ? r_shift : 3'h0;
  assign aluCarryIn = w_exec & r_carry[r_owner];

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: real ALU attached, cycle-level reference model, directed + random traffic.
module tb_alu_arbiter;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      reqValid, reqReady, respValid, respReady;
  logic [1:0][3:0] reqOp;
  logic [1:0][7:0] reqA, reqB;
  logic [1:0][2:0] reqShift;
  logic [7:0]      respResult, aluA, aluB, aluResult;
  logic            respCarry, respZero, aluCarryIn, aluCarryOut, aluZero;
  logic [3:0]      aluOp;
  logic [2:0]      aluShift;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp), .reqA(reqA), .reqB(reqB),
    .reqShift(reqShift), .respValid(respValid), .respReady(respReady),
    .respResult(respResult), .respCarry(respCarry), .respZero(respZero),
    .aluA(aluA), .aluB(aluB), .aluOp(aluOp), .aluCarryIn(aluCarryIn), .aluShift(aluShift),
    .aluResult(aluResult), .aluCarryOut(aluCarryOut), .aluZero(aluZero)
  );

  // The shared 8-bit ALU
  logic [8:0]  t9;
  logic [15:0] t16;
  always_comb begin
    t9 = '0; t16 = '0;
    aluResult = aluA; aluCarryOut = 1'b0;
    case (aluOp)
      4'b1000: begin t9 = {1'b0, aluA} + {1'b0, aluB}; {aluCarryOut, aluResult} = t9; end
      4'b1001: begin t9 = {1'b0, aluA} + {1'b0, aluB} + {8'b0, aluCarryIn}; {aluCarryOut, aluResult} = t9; end
      4'b1010: begin t9 = {1'b0, aluA} - {1'b0, aluB}; {aluCarryOut, aluResult} = t9; end
      4'b1011: begin t9 = {1'b0, aluA} - {1'b0, aluB} - {8'b0, aluCarryIn}; {aluCarryOut, aluResult} = t9; end
      4'b1100: aluResult = aluA & aluB;
      4'b1101: aluResult = aluA | aluB;
      4'b1110: aluResult = aluA ^ aluB;
      4'b1111: aluResult = aluA & ~aluB;
      4'b0000: aluResult = aluA << aluShift;
      4'b0001: aluResult = aluA >> aluShift;
      4'b0010: begin t16 = {aluA, aluA} << aluShift; aluResult = t16[15:8]; end
      4'b0011: begin t16 = {aluA, aluA} >> aluShift; aluResult = t16[7:0]; end
      default: aluResult = aluA;
    endcase
  end
  assign aluZero = (aluResult == 8'h00);

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: phase 0 = free, 1 = ALU cycle, 2 = result on offer
  int         m_phase;
  logic       m_last, m_own, m_hs;
  logic [1:0] m_carry;
  logic [3:0] m_op;
  logic [7:0] m_a, m_b, m_res;
  logic [2:0] m_sh;
  logic       m_co, m_z;

  logic [1:0] obs_rdy, obs_rv;
  logic [7:0] obs_res;
  logic       obs_cin, obs_co, obs_z;

  function automatic logic [1:0] pick(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  function automatic logic [8:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] sh, input logic cin);
    int ia = a, ib = b, n = sh, c = cin, s;
    logic co;
    co = 1'b0;
    case (op)
      4'd8:  s = ia + ib;
      4'd9:  s = ia + ib + c;
      4'd10: s = ia - ib;
      4'd11: s = ia - ib - c;
      4'd12: s = ia & ib;
      4'd13: s = ia | ib;
      4'd14: s = ia ^ ib;
      4'd15: s = ia & (255 - ib);
      4'd0:  s = ia * (1 << n);
      4'd1:  s = ia / (1 << n);
      4'd2:  s = (ia * (1 << n)) | (ia >> (8 - n));
      4'd3:  s = (ia >> n) | (ia * (1 << (8 - n)));
      default: s = ia;
    endcase
    if (op >= 4'd8 && op <= 4'd11) co = (s > 255) || (s < 0);
    return {co, 8'(s & 255)};
  endfunction

  task automatic step();
    logic [1:0]      v, rr, g;
    logic [1:0][3:0] op;
    logic [1:0][7:0] a, b;
    logic [1:0][2:0] sh;
    logic [8:0]      r;
    @(negedge clk);
    obs_rdy = reqReady; obs_rv = respValid; obs_cin = aluCarryIn;
    obs_res = respResult; obs_co = respCarry; obs_z = respZero;
    v = reqValid; rr = respReady; op = reqOp; a = reqA; b = reqB; sh = reqShift;
    case (m_phase)
      0: begin
        chk("idle_rdy", reqReady, pick(v, m_last));
        chk("idle_rv", respValid, 2'b00);
        chk("idle_alu", {aluA, aluB, aluOp, aluCarryIn, aluShift}, 0);
      end
      1: begin
        chk("exec_rdy", reqReady, 2'b00);
        chk("exec_rv", respValid, 2'b00);
        chk("exec_alu", {aluA, aluB, aluOp, aluShift}, {m_a, m_b, m_op, m_sh});
        chk("exec_cin", aluCarryIn, m_carry[m_own]);
      end
      default: begin
        chk("resp_rdy", reqReady, 2'b00);
        chk("resp_rv", respValid, m_own ? 2'b10 : 2'b01);
        chk("resp_data", {respResult, respCarry, respZero}, {m_res, m_co, m_z});
      end
    endcase
    @(posedge clk); #1;
    m_hs = 1'b0;
    if (m_phase == 0) begin
      g = pick(v, m_last);
      if (g != 2'b00) begin
        m_own = g[1]; m_op = op[m_own]; m_a = a[m_own]; m_b = b[m_own]; m_sh = sh[m_own];
        m_last = m_own; m_hs = 1'b1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      r = ref_alu(m_op, m_a, m_b, m_sh, m_carry[m_own]);
      m_res = r[7:0]; m_co = r[8]; m_z = (r[7:0] == 8'h00);
      if (m_op >= 4'd8 && m_op <= 4'd11) m_carry[m_own] = r[8];
      m_phase = 2;
    end else if (rr[m_own]) begin
      m_phase = 0;
    end
  endtask

  task automatic do_reset();
    logic [1:0] sv;
    sv = reqValid;
    rst = 1'b1; reqValid = 2'b11;
    @(negedge clk);
    chk("rst_out", {reqReady, respValid, respResult, respCarry, respZero,
                    aluA, aluB, aluOp, aluCarryIn, aluShift}, 0);
    @(posedge clk); #1;
    rst = 1'b0; reqValid = sv;
    m_phase = 0; m_carry = 2'b00; m_last = 1'b1; m_hs = 1'b0;
  endtask

  task automatic wait_hs(input string tag);
    logic done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      step();
      if (m_hs) done = 1'b1;
    end
    if (!done) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic run_op(input logic i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_res, input logic exp_cin, input string tag);
    reqOp[i] = op; reqA[i] = a; reqB[i] = b; reqShift[i] = 3'd0; reqValid[i] = 1'b1;
    wait_hs(tag);
    chk({tag, "_grant"}, obs_rdy, i ? 2'b10 : 2'b01);
    reqValid[i] = 1'b0;
    step();
    chk({tag, "_cin"}, obs_cin, exp_cin);
    step();
    chk({tag, "_rv"}, obs_rv, i ? 2'b10 : 2'b01);
    chk({tag, "_res"}, obs_res, exp_res);
  endtask

  initial begin
    rst = 1'b1; reqValid = '0; reqOp = '0; reqA = '0; reqB = '0; reqShift = '0; respReady = 2'b11;
    m_own = 0; m_op = 0; m_a = 0; m_b = 0; m_sh = 0; m_res = 0; m_co = 0; m_z = 0;
    do_reset();
    step();

    // Carry path: ADD sets carry0, ADC consumes it per requester
    run_op(1'b0, 4'b1000, 8'hF0, 8'h20, 8'h10, 1'b0, "add");
    chk("add_carry", obs_co, 1'b1);
    chk("add_zero", obs_z, 1'b0);
    run_op(1'b0, 4'b1001, 8'h01, 8'h01, 8'h03, 1'b1, "adc0");
    run_op(1'b1, 4'b1001, 8'h01, 8'h01, 8'h02, 1'b0, "adc1");

    // Logic op keeps the carry flag
    run_op(1'b0, 4'b1000, 8'hF0, 8'h20, 8'h10, 1'b0, "add2");
    run_op(1'b0, 4'b1110, 8'h5A, 8'h5A, 8'h00, 1'b1, "xor");
    chk("xor_zero", obs_z, 1'b1);
    run_op(1'b0, 4'b1001, 8'h00, 8'h00, 8'h01, 1'b1, "adc_after_xor");

    // Backpressure on requester 0 with requester 1 pending
    reqOp[0] = 4'b1000; reqA[0] = 8'h01; reqB[0] = 8'h02; reqValid[0] = 1'b1;
    wait_hs("hold");
    reqValid[0] = 1'b0;
    reqOp[1] = 4'b1101; reqA[1] = 8'h0F; reqB[1] = 8'hF0; reqValid[1] = 1'b1;
    respReady[0] = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_rv", obs_rv, 2'b01);
      chk("hold_res", obs_res, 8'h03);
      chk("hold_rdy", obs_rdy, 2'b00);
    end
    respReady[0] = 1'b1;
    step();
    step();
    chk("pend_grant", obs_rdy, 2'b10);
    reqValid[1] = 1'b0;
    step(); step(); step();

    // Reset in EXEC aborts the ADD and leaves carry0 clear
    reqOp[0] = 4'b1000; reqA[0] = 8'hF0; reqB[0] = 8'h20; reqValid[0] = 1'b1;
    wait_hs("abort");
    reqValid[0] = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("abort_rv", obs_rv, 2'b00);
    end
    run_op(1'b0, 4'b1001, 8'h00, 8'h00, 8'h00, 1'b0, "adc_after_abort");

    // Round-robin with both requesters always valid
    do_reset();
    reqOp[0] = 4'b1100; reqA[0] = 8'h3C; reqB[0] = 8'hF0;
    reqOp[1] = 4'b0010; reqA[1] = 8'h81; reqShift[1] = 3'd1;
    reqValid = 2'b11; respReady = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_hs("rr");
      chk("rr_grant", obs_rdy, (k % 2) ? 2'b10 : 2'b01);
    end
    reqValid = 2'b00;
    step(); step(); step();

    // Random traffic; a request is held until accepted
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!reqValid[i] && $urandom_range(1, 0) == 1) begin
          reqOp[i] = 4'($urandom_range(15, 0)); reqA[i] = 8'($urandom_range(255, 0));
          reqB[i] = 8'($urandom_range(255, 0)); reqShift[i] = 3'($urandom_range(7, 0));
          reqValid[i] = 1'b1;
        end
      end
      respReady = 2'($urandom_range(3, 0));
      if ($urandom_range(79, 0) == 0) do_reset();
      else begin
        step();
        if (m_hs) reqValid[m_own] = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
